// File: rtl/frame_capture_sequencer.sv
// Picks a decimated COLS x ROWS window out of an HDMI frame and sequences its writes into a
// double-buffered frame store, swapping banks with the output side under a ready/ack handshake.
module frame_capture_sequencer #(
    parameter int unsigned ADDRESS_BITS = 8,
    parameter int unsigned COLS         = 16,
    parameter int unsigned ROWS         = 8,
    parameter int unsigned X_OFFSET     = 0,
    parameter int unsigned Y_OFFSET     = 0,
    parameter int unsigned H_STEP       = 80,
    parameter int unsigned V_STEP       = 90
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_enable,
    input  logic        I_de,
    input  logic        I_vsync,
    input  logic [23:0] I_pixel,
    input  logic        I_frame_ack,
    output logic [23:0] O_pixel,
    output logic        O_write_en,
    output logic        O_address_up,
    output logic        O_address_reset,
    output logic        O_write_bank,
    output logic        O_frame_ready,
    output logic        O_frame_error,
    output logic        O_frame_drop
);

    localparam logic [11:0] XOff  = 12'(X_OFFSET);
    localparam logic [11:0] YOff  = 12'(Y_OFFSET);
    localparam logic [11:0] HLast = 12'(H_STEP - 1);
    localparam logic [11:0] VLast = 12'(V_STEP - 1);
    localparam logic [11:0] ColsL = 12'(COLS);
    localparam logic [11:0] RowsL = 12'(ROWS);
    localparam logic [ADDRESS_BITS:0] TotalW = (ADDRESS_BITS + 1)'(COLS * ROWS);

    typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

    state_e                state_q;
    logic                  vsync_q, de_q;
    logic [11:0]           x_q, y_q, h_ph_q, v_ph_q, col_q, row_q;
    logic [ADDRESS_BITS:0] wr_cnt_q;

    logic vsync_rise, de_fall, x_ge, y_ge, hit, frame_last;

    assign vsync_rise = I_vsync & ~vsync_q;
    assign de_fall    = ~I_de & de_q;
    assign x_ge       = x_q >= XOff;
    assign y_ge       = y_q >= YOff;
    // Phase counters stand in for (x-X_OFFSET)%H_STEP and (y-Y_OFFSET)%V_STEP.
    assign hit        = I_de && x_ge && (h_ph_q == '0) && (col_q < ColsL)
                        && y_ge && (v_ph_q == '0) && (row_q < RowsL);
    assign frame_last = O_address_up && (wr_cnt_q == TotalW);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            h_ph_q  <= '0;
            v_ph_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            vsync_q <= I_vsync;
            de_q    <= I_de;
            if (I_de) begin
                if (x_q != '1) x_q <= x_q + 12'd1;
                if (x_ge) begin
                    h_ph_q <= (h_ph_q == HLast) ? '0 : h_ph_q + 12'd1;
                    if ((h_ph_q == '0) && (col_q < ColsL)) col_q <= col_q + 12'd1;
                end
            end else begin
                x_q    <= '0;
                h_ph_q <= '0;
                col_q  <= '0;
            end
            if (vsync_rise) begin
                y_q    <= '0;
                v_ph_q <= '0;
                row_q  <= '0;
            end else if (de_fall) begin
                if (y_q != '1) y_q <= y_q + 12'd1;
                if (y_ge) begin
                    v_ph_q <= (v_ph_q == VLast) ? '0 : v_ph_q + 12'd1;
                    if ((v_ph_q == '0) && (row_q < RowsL)) row_q <= row_q + 12'd1;
                end
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q         <= StIdle;
            wr_cnt_q        <= '0;
            O_pixel         <= '0;
            O_write_en      <= 1'b0;
            O_address_up    <= 1'b0;
            O_address_reset <= 1'b0;
            O_write_bank    <= 1'b0;
            O_frame_ready   <= 1'b0;
            O_frame_error   <= 1'b0;
            O_frame_drop    <= 1'b0;
        end else begin
            O_write_en      <= 1'b0;
            O_address_up    <= 1'b0;
            O_address_reset <= 1'b0;
            O_frame_error   <= 1'b0;
            O_frame_drop    <= 1'b0;
            if (I_frame_ack) O_frame_ready <= 1'b0;
            case (state_q)
                StCapture: begin
                    if (frame_last) begin
                        state_q <= StDone;
                        if (!O_frame_ready || I_frame_ack) begin
                            O_write_bank  <= ~O_write_bank;
                            O_frame_ready <= 1'b1;
                        end else begin
                            O_frame_drop <= 1'b1;
                        end
                    end else if (vsync_rise) begin
                        // Short frame: any pending up pulse is dropped so reset never overlaps it.
                        O_frame_error   <= 1'b1;
                        O_address_reset <= 1'b1;
                        wr_cnt_q        <= '0;
                        state_q         <= I_enable ? StCapture : StIdle;
                    end else begin
                        O_address_up <= O_write_en;
                        if (hit) begin
                            O_write_en <= 1'b1;
                            O_pixel    <= I_pixel;
                            wr_cnt_q   <= wr_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    if (vsync_rise && I_enable) begin
                        state_q         <= StCapture;
                        O_address_reset <= 1'b1;
                        wr_cnt_q        <= '0;
                    end
                end
            endcase
        end
    end

endmodule
